// File: rtl/led_bank_ctrl_if.sv
// Configuration handshake bundle for led_bank_ctrl.
//   cfg_valid_i   : configuration offered (master -> slave)
//   cfg_ready_o   : configuration can be accepted (slave -> master)
//   cfg_mode_i    : 0 static, 1 blink, 2 rotate-left, 3 count
//   cfg_pattern_i : initial value / blink pattern
//   cfg_mask_i    : 1 = bit is written by this config and its ticks
//   cfg_presc_i   : tick period minus one
interface led_bank_ctrl_if #(
  parameter int NumLeds    = 8,
  parameter int PrescWidth = 16
);
  logic                  cfg_valid_i;
  logic                  cfg_ready_o;
  logic [1:0]            cfg_mode_i;
  logic [NumLeds-1:0]    cfg_pattern_i;
  logic [NumLeds-1:0]    cfg_mask_i;
  logic [PrescWidth-1:0] cfg_presc_i;

  modport master (
    output cfg_valid_i, cfg_mode_i, cfg_pattern_i, cfg_mask_i, cfg_presc_i,
    input  cfg_ready_o
  );

  modport slave (
    input  cfg_valid_i, cfg_mode_i, cfg_pattern_i, cfg_mask_i, cfg_presc_i,
    output cfg_ready_o
  );
endinterface

// File: rtl/led_bank_ctrl.sv
// Pattern sequencer for a bank of disabled-hold D-flip-flop LED cells.
// Accepts a mode/pattern/mask/period config and emits one-cycle per-bit write
// strobes (led_dis_o low) carrying data on led_d_o. shadow_o mirrors what the
// downstream cells hold, since the cells themselves have no reset.
//   clk_i, rst_ni : clock (shared with cells), async active-low reset
//   cfg           : configuration handshake (slave side)
//   led_d_o       : cell data inputs
//   led_dis_o     : cell disable inputs, 1 = hold, 0 = load
//   shadow_o      : mirror of the cell contents
module led_bank_ctrl #(
  parameter int NumLeds    = 8,
  parameter int PrescWidth = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  led_bank_ctrl_if.slave     cfg,
  output logic [NumLeds-1:0] led_d_o,
  output logic [NumLeds-1:0] led_dis_o,
  output logic [NumLeds-1:0] shadow_o
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  localparam logic [1:0] ModeStatic = 2'd0;
  localparam logic [1:0] ModeBlink  = 2'd1;
  localparam logic [1:0] ModeRotate = 2'd2;
  localparam logic [1:0] ModeCount  = 2'd3;

  localparam logic [NumLeds-1:0]    LedOne = {{(NumLeds-1){1'b0}}, 1'b1};
  localparam logic [PrescWidth-1:0] CntOne = {{(PrescWidth-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [NumLeds-1:0]    pattern_q, pattern_d;
  logic [NumLeds-1:0]    mask_q, mask_d;
  logic [PrescWidth-1:0] presc_q, presc_d;
  logic [PrescWidth-1:0] cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic [NumLeds-1:0]    led_d_q, led_d_d;
  logic [NumLeds-1:0]    led_dis_q, led_dis_d;
  logic [NumLeds-1:0]    shadow_q, shadow_d;
  logic                  ready_q, ready_d;

  logic                  accept, wrap, tick, wr;
  logic [NumLeds-1:0]    wr_val, wr_mask;

  assign accept = cfg.cfg_valid_i & ready_q;
  assign wrap   = (cnt_q == presc_q);
  // Static mode keeps the prescaler cycling but never turns a wrap into a write.
  assign tick   = (state_q == ST_RUN) && wrap && (mode_q != ModeStatic);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_INIT;
    else         state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // INIT holds for exactly one cycle so the cells see at least one clearing edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // ---------------- config capture, prescaler and write value ----------------
  always_comb begin
    mode_d    = mode_q;
    pattern_d = pattern_q;
    mask_d    = mask_q;
    presc_d   = presc_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    wr        = 1'b0;
    wr_val    = '0;
    wr_mask   = '0;

    if (state_q == ST_RUN) cnt_d = wrap ? '0 : cnt_q + CntOne;

    // Accept takes priority over a coincident tick and restarts the prescaler.
    if (accept) begin
      mode_d    = cfg.cfg_mode_i;
      pattern_d = cfg.cfg_pattern_i;
      mask_d    = cfg.cfg_mask_i;
      presc_d   = cfg.cfg_presc_i;
      cnt_d     = '0;
      phase_d   = 1'b1;
      wr        = 1'b1;
      wr_val    = cfg.cfg_pattern_i;
      wr_mask   = cfg.cfg_mask_i;
    end else if (tick) begin
      wr      = 1'b1;
      wr_mask = mask_q;
      case (mode_q)
        ModeBlink: begin
          phase_d = ~phase_q;
          wr_val  = phase_q ? '0 : pattern_q;  // value follows the new phase
        end
        // Rotate/count work on the full shadow, including unmasked bits.
        ModeRotate: wr_val = {shadow_q[NumLeds-2:0], shadow_q[NumLeds-1]};
        ModeCount:  wr_val = shadow_q + LedOne;
        default:    wr_val = '0;
      endcase
    end
  end

  // ---------------- FSM: outputs (registered) ----------------
  always_comb begin
    ready_d   = (state_d == ST_RUN);
    led_dis_d = wr ? ~wr_mask : '1;
    led_d_d   = wr ? (wr_val & wr_mask) : led_d_q;
    shadow_d  = wr ? ((wr_val & wr_mask) | (shadow_q & ~wr_mask)) : shadow_q;
  end

  // Reset drives dis=0/d=0 so the cells clear on every edge while reset is held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q    <= ModeStatic;
      pattern_q <= '0;
      mask_q    <= '0;
      presc_q   <= '0;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
      led_d_q   <= '0;
      led_dis_q <= '0;
      shadow_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      pattern_q <= pattern_d;
      mask_q    <= mask_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      led_d_q   <= led_d_d;
      led_dis_q <= led_dis_d;
      shadow_q  <= shadow_d;
      ready_q   <= ready_d;
    end
  end

  assign led_d_o         = led_d_q;
  assign led_dis_o       = led_dis_q;
  assign shadow_o        = shadow_q;
  assign cfg.cfg_ready_o = ready_q;

endmodule
